// File: rtl/alu_bist_pkg.sv
// alu_bist_pkg
// Shared types and helpers for the ALU built-in self-test engine:
//   alu_op_e      - ALU opcode encoding (ADD, SUB, AND, OR)
//   bist_state_e  - BIST sequencer states
//   LFSR_TAPS     - tap mask for x^16 + x^14 + x^13 + x^11 + 1
//   alu_resp_t    - 7-bit ALU response {result, carry, zero, overflow}
//   lfsr_step     - one Fibonacci shift of the 16-bit LFSR
//   alu_ref       - golden model of the 4-bit ALU
package alu_bist_pkg;

    typedef enum logic [1:0] {
        OP_ADD = 2'b00,
        OP_SUB = 2'b01,
        OP_AND = 2'b10,
        OP_OR  = 2'b11
    } alu_op_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_CHECK,
        ST_DONE
    } bist_state_e;

    // Bits 15, 13, 12 and 10 feed the XOR that re-enters at bit 0.
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    typedef struct packed {
        logic [3:0] result;
        logic       carry;
        logic       zero;
        logic       overflow;
    } alu_resp_t;

    function automatic logic [15:0] lfsr_step(input logic [15:0] v);
        return {v[14:0], ^(v & LFSR_TAPS)};
    endfunction

    // SUB is computed as A + ~B + 1 so carry reads as "no borrow".
    function automatic alu_resp_t alu_ref(input logic [3:0] a, input logic [3:0] b,
                                          input alu_op_e op);
        alu_resp_t  r;
        logic [4:0] s;
        r = '0;
        s = '0;
        case (op)
            OP_ADD: begin
                s          = {1'b0, a} + {1'b0, b};
                r.result   = s[3:0];
                r.carry    = s[4];
                r.overflow = (a[3] == b[3]) && (s[3] != a[3]);
            end
            OP_SUB: begin
                s          = {1'b0, a} + {1'b0, ~b} + 5'd1;
                r.result   = s[3:0];
                r.carry    = s[4];
                r.overflow = (a[3] != b[3]) && (s[3] != a[3]);
            end
            OP_AND:  r.result = a & b;
            default: r.result = a | b;
        endcase
        r.zero = (r.result == 4'd0);
        return r;
    endfunction

endpackage

// File: rtl/bist_lfsr16.sv
// bist_lfsr16
// 16-bit Fibonacci LFSR with parallel load and an XOR input, usable both as
// a pattern generator (xor_in tied to zero) and as a MISR (xor_in = data).
// Ports:
//   clk, rst_n   - clock, synchronous active-low reset (value <= RESET_VALUE)
//   load         - load load_value (has priority over step)
//   load_value   - value loaded on load
//   step         - advance one shift and fold in xor_in
//   xor_in       - data compacted into the register on each step
//   value        - current register contents
module bist_lfsr16
    import alu_bist_pkg::*;
#(
    parameter logic [15:0] RESET_VALUE = 16'h0001
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic [15:0] load_value,
    input  logic        step,
    input  logic [15:0] xor_in,
    output logic [15:0] value
);

    // Load wins over step so a run restart always begins from a known value.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            value <= RESET_VALUE;
        end else if (load) begin
            value <= load_value;
        end else if (step) begin
            value <= lfsr_step(value) ^ xor_in;
        end
    end

endmodule

// File: rtl/alu_bist_engine.sv
// alu_bist_engine
// Built-in self-test initiator for the 4-bit ALU. Issues LFSR-generated
// A/B/op vectors over a start/valid handshake, checks every response
// against the golden model, counts mismatches, records the first failing
// index and compacts all responses into a MISR signature.
// Ports:
//   clk, rst_n        - clock, synchronous active-low reset
//   bist_start        - level; a rising edge in IDLE or DONE starts a run
//   bist_busy         - high in ISSUE, WAIT and CHECK
//   bist_done         - high in DONE
//   bist_pass         - valid with bist_done; no mismatch and no timeout
//   timeout_err       - sticky per run, ALU failed to answer in time
//   mismatch_count    - saturating count of failing vectors
//   first_fail_idx    - index of first failing vector, 16'hFFFF if none
//   signature         - MISR value
//   alu_a/alu_b/alu_op, alu_start          - request to the ALU
//   alu_valid, alu_result, alu_carry,
//   alu_zero, alu_overflow                 - response from the ALU
module alu_bist_engine
    import alu_bist_pkg::*;
#(
    parameter int unsigned NUM_VECTORS = 10000,
    parameter logic [15:0] LFSR_SEED   = 16'hACE1,
    parameter int unsigned TIMEOUT     = 16,
    parameter logic [15:0] MISR_INIT   = 16'hFFFF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        bist_start,
    output logic        bist_busy,
    output logic        bist_done,
    output logic        bist_pass,
    output logic        timeout_err,
    output logic [15:0] mismatch_count,
    output logic [15:0] first_fail_idx,
    output logic [15:0] signature,
    output logic [3:0]  alu_a,
    output logic [3:0]  alu_b,
    output logic [1:0]  alu_op,
    output logic        alu_start,
    input  logic        alu_valid,
    input  logic [3:0]  alu_result,
    input  logic        alu_carry,
    input  logic        alu_zero,
    input  logic        alu_overflow
);

    // An all-zero seed would lock the LFSR, so it is replaced by 1.
    localparam logic [15:0] SEED_EFF   = (LFSR_SEED == 16'h0000) ? 16'h0001 : LFSR_SEED;
    localparam logic [15:0] LAST_IDX   = 16'(NUM_VECTORS - 1);
    localparam logic [15:0] WAIT_LIMIT = 16'(TIMEOUT);

    bist_state_e state;
    bist_state_e state_next;

    logic        start_q;
    logic        start_rise;
    logic [15:0] lfsr_value;
    logic [15:0] idx;
    logic [15:0] wait_cnt;
    alu_resp_t   resp_q;
    alu_resp_t   expected;
    logic        fail_seen;
    logic        mismatch;
    logic        last_vec;
    logic        timeout_hit;
    logic        run_load;
    logic        check_en;
    logic        lfsr_adv;
    logic        wait_expire;
    logic        lfsr_unused;

    assign start_rise  = bist_start & ~start_q;
    assign last_vec    = (idx == LAST_IDX);
    assign timeout_hit = ((wait_cnt + 16'd1) == WAIT_LIMIT);

    // Operands come straight from the stimulus LFSR; it only moves on the
    // CHECK->ISSUE edge, so they stay stable for the whole transaction.
    assign alu_a       = lfsr_value[3:0];
    assign alu_b       = lfsr_value[7:4];
    assign alu_op      = lfsr_value[9:8];
    assign lfsr_unused = ^lfsr_value[15:10];

    assign expected = alu_ref(alu_a, alu_b, alu_op_e'(alu_op));
    assign mismatch = (resp_q != expected);

    bist_lfsr16 #(
        .RESET_VALUE (16'h0000)
    ) u_stim_lfsr (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (run_load),
        .load_value (SEED_EFF),
        .step       (lfsr_adv),
        .xor_in     (16'h0000),
        .value      (lfsr_value)
    );

    bist_lfsr16 #(
        .RESET_VALUE (MISR_INIT)
    ) u_misr (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (run_load),
        .load_value (MISR_INIT),
        .step       (check_en),
        .xor_in     ({9'b0, resp_q}),
        .value      (signature)
    );

    // Sequencer state register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic and per-state strobes. A valid response in WAIT takes
    // priority over a timeout landing in the same cycle.
    always_comb begin
        state_next  = state;
        bist_busy   = 1'b0;
        bist_done   = 1'b0;
        alu_start   = 1'b0;
        run_load    = 1'b0;
        check_en    = 1'b0;
        lfsr_adv    = 1'b0;
        wait_expire = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start_rise) begin
                    run_load   = 1'b1;
                    state_next = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                bist_busy  = 1'b1;
                alu_start  = 1'b1;
                state_next = ST_WAIT;
            end
            ST_WAIT: begin
                bist_busy = 1'b1;
                if (alu_valid) begin
                    state_next = ST_CHECK;
                end else if (timeout_hit) begin
                    wait_expire = 1'b1;
                    state_next  = ST_DONE;
                end
            end
            ST_CHECK: begin
                bist_busy = 1'b1;
                check_en  = 1'b1;
                if (last_vec) begin
                    state_next = ST_DONE;
                end else begin
                    lfsr_adv   = 1'b1;
                    state_next = ST_ISSUE;
                end
            end
            ST_DONE: begin
                bist_done = 1'b1;
                if (start_rise) begin
                    run_load   = 1'b1;
                    state_next = ST_ISSUE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Run bookkeeping: response capture, wait counter, mismatch statistics
    // and the pass verdict. fail_seen tracks "first_fail_idx already set"
    // and also folds the timeout into the pass verdict.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            start_q        <= 1'b0;
            idx            <= '0;
            wait_cnt       <= '0;
            resp_q         <= '0;
            fail_seen      <= 1'b0;
            mismatch_count <= '0;
            first_fail_idx <= 16'hFFFF;
            timeout_err    <= 1'b0;
            bist_pass      <= 1'b0;
        end else begin
            start_q <= bist_start;

            if (run_load) begin
                idx            <= '0;
                fail_seen      <= 1'b0;
                mismatch_count <= '0;
                first_fail_idx <= 16'hFFFF;
                timeout_err    <= 1'b0;
                bist_pass      <= 1'b0;
            end

            if (state == ST_ISSUE) begin
                wait_cnt <= '0;
            end

            if (state == ST_WAIT) begin
                if (alu_valid) begin
                    resp_q <= {alu_result, alu_carry, alu_zero, alu_overflow};
                end else begin
                    wait_cnt <= wait_cnt + 16'd1;
                end
            end

            if (wait_expire) begin
                timeout_err <= 1'b1;
                bist_pass   <= 1'b0;
                fail_seen   <= 1'b1;
                if (!fail_seen) begin
                    first_fail_idx <= idx;
                end
            end

            if (check_en) begin
                if (mismatch) begin
                    if (mismatch_count != 16'hFFFF) begin
                        mismatch_count <= mismatch_count + 16'd1;
                    end
                    if (!fail_seen) begin
                        first_fail_idx <= idx;
                    end
                    fail_seen <= 1'b1;
                end
                if (last_vec) begin
                    bist_pass <= ~(fail_seen | mismatch);
                end else begin
                    idx <= idx + 16'd1;
                end
            end
        end
    end

endmodule

// File: doc/alu_bist_engine.md
Name: alu_bist_engine

Overview:
- On-chip built-in self-test initiator for the 4-bit secure ALU; drives it the way the verification bench does, but in hardware.
- Generates pseudo-random A/B/op vectors from an LFSR and issues them over a start/valid handshake.
- Checks each ALU response against an internal golden model, counts mismatches, records the first failing index and compacts all responses into a MISR signature.
- Sits beside the ALU under test; used for field trojan/fault screening.

Parameters:
- NUM_VECTORS, 10000: vectors per run; legal range 1..65535.
- LFSR_SEED, 16'hACE1: LFSR value loaded at run start; 0 is replaced by 16'h0001.
- TIMEOUT, 16: max cycles in WAIT for alu_valid before aborting.
- MISR_INIT, 16'hFFFF: MISR value loaded at run start.

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous, active-low reset
- bist_start  in  1  level; rising edge sampled in IDLE or DONE starts a run
- bist_busy  out  1  high from ISSUE through CHECK
- bist_done  out  1  high in DONE
- bist_pass  out  1  valid when bist_done; 1 = zero mismatches and no timeout
- timeout_err  out  1  sticky per run; set on WAIT timeout
- mismatch_count  out  16  saturating count of failing vectors
- first_fail_idx  out  16  index of first failing vector; 16'hFFFF if none
- signature  out  16  MISR value
- alu_a  out  4  operand A
- alu_b  out  4  operand B
- alu_op  out  2  opcode: 00 ADD, 01 SUB, 10 AND, 11 OR
- alu_start  out  1  one-cycle request pulse
- alu_valid  in  1  ALU result valid (WB stage)
- alu_result  in  4  ALU result
- alu_carry  in  1  ALU carry flag
- alu_zero  in  1  ALU zero flag
- alu_overflow  in  1  ALU overflow flag

Behaviour:
Reset:
- Reset is synchronous, active-low (rst_n); clock is clk.
- All outputs are 0 except first_fail_idx = 16'hFFFF and signature = MISR_INIT. FSM goes to IDLE.
- Reset asserted mid-run aborts the run immediately; no done pulse is produced.

FSM states: IDLE, ISSUE, WAIT, CHECK, DONE.
- IDLE / DONE: on a bist_start rising edge, load lfsr = LFSR_SEED, misr = MISR_INIT, idx = 0, clear count, timeout_err and first_fail_idx; go to ISSUE. DONE otherwise holds all results.
- ISSUE:
  - alu_a = lfsr[3:0], alu_b = lfsr[7:4], alu_op = lfsr[9:8].
  - alu_start = 1 for exactly this cycle; clear the wait counter; go to WAIT.
- WAIT:
  - alu_valid = 1: capture result and flags; go to CHECK.
  - Otherwise increment the wait counter. When it reaches TIMEOUT: set timeout_err, set bist_pass = 0, record first_fail_idx if still unset, go to DONE.
- CHECK:
  - Compare the captured 7-bit response {result, carry, zero, overflow} with the golden model.
  - On mismatch: increment count, saturating at 16'hFFFF; record first_fail_idx = idx if unset.
  - Update MISR.
  - If idx == NUM_VECTORS-1: go to DONE with bist_pass = (count == 0).
  - Else: advance the LFSR, increment idx, go to ISSUE.

Handshake rules:
- alu_a, alu_b and alu_op are held stable from ISSUE through CHECK; they change only on ISSUE entry.
- alu_valid outside WAIT is ignored.
- Per-vector latency = 1 + (ALU latency) + 1 cycles.

Golden model:
- ADD: s = A + B (5 bits); result = s[3:0]; carry = s[4]; overflow = (A[3] == B[3]) && (result[3] != A[3]).
- SUB: s = A + ~B + 1 (5 bits); result = s[3:0]; carry = s[4] (1 = no borrow); overflow = (A[3] != B[3]) && (result[3] != A[3]).
- AND / OR: bitwise result; carry = 0; overflow = 0.
- zero = (result == 0) for all ops.

LFSR:
- 16-bit Fibonacci, polynomial x^16 + x^14 + x^13 + x^11 + 1.
- Shift left; feedback into bit 0 = b15 ^ b13 ^ b12 ^ b10.

MISR:
- misr_next = lfsr_step(misr) ^ {9'b0, result, carry, zero, overflow}, using the same polynomial.
- Updated once per CHECK; not updated on timeout.

Decomposition:
- Package alu_bist_pkg:
  - alu_op_e enum (ADD/SUB/AND/OR).
  - bist_state_e enum.
  - LFSR tap constant.
  - alu_resp_t packed struct {result, carry, zero, overflow}.
  - Golden-model function alu_ref.
- One sub-module, bist_lfsr16 (load, step, value). It is instantiated twice: once as the stimulus LFSR and once as the MISR, with the MISR instance given an XOR input port.

Test Plan:
1. LFSR_SEED = 16'h0123, NUM_VECTORS = 1, correct ALU model with 3-cycle latency → vector A=3, B=2, op=SUB; response result=1, carry=1, zero=0, ovf=0; bist_pass=1, count=0, first_fail_idx=FFFF; bist_done 5 cycles after ISSUE.
2. Default parameters, correct ALU model → bist_pass=1, count=0; signature equals the bench's reference MISR after 10000 vectors; alu_start pulses exactly 10000 times, each 1 cycle wide.
3. Faulty ALU that flips result[0] when A=4'hF and B=4'hF → count equals the bench-predicted number of such vectors; first_fail_idx = first such index; bist_pass=0.
4. ALU never asserts alu_valid → timeout_err=1 and bist_done=1 exactly TIMEOUT cycles after WAIT entry; bist_pass=0; first_fail_idx=0.
5. rst_n low for 1 cycle mid-run (idx≈500) → next cycle shows IDLE, busy=0, count=0, signature=MISR_INIT; a subsequent bist_start rerun matches scenario 2.
6. alu_valid pulsed during ISSUE and CHECK, plus operand-stability assertion during WAIT → spurious valids ignored; results identical to scenario 2.
